// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shifter
//  Purpose  : Multi-cycle SLL/SRL/SRA unit, STEP bit positions per cycle,
//             valid/ready on both request and result sides.
//             Define SEQ_SHIFTER_ROTATE_EN to make op 2'b10 a rotate-right.
//  Revision : 1.0  initial release
// ============================================================================
module seq_shifter #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              op,
    input  logic [$clog2(XLEN)-1:0] shamt,
    input  logic [XLEN-1:0]         datain,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         dataout,
    output logic                    busy
);

    localparam int             SHW      = $clog2(XLEN);
    localparam logic [SHW-1:0] C_STEP   = SHW'(STEP);
    localparam logic [1:0]     C_OP_SLL = 2'b00;
    localparam logic [1:0]     C_OP_SRL = 2'b01;
    localparam logic [1:0]     C_OP_SRA = 2'b11;
`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam logic [1:0]     C_OP_ROR = 2'b10;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;
    logic [XLEN-1:0] dataout_q;
    logic [SHW-1:0]  rem_q;
    logic [SHW-1:0]  rem_d;
    logic [SHW-1:0]  k;
    logic [1:0]      op_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    // SRA keeps the MSB in place, so bit XLEN-1 always equals the original sign.
    function automatic logic [XLEN-1:0] f_shift1(input logic [XLEN-1:0] d,
                                                 input logic [1:0]      o);
        logic [XLEN-1:0] r;
        case (o)
            C_OP_SLL: r = {d[XLEN-2:0], 1'b0};
            C_OP_SRL: r = {1'b0, d[XLEN-1:1]};
            C_OP_SRA: r = {d[XLEN-1], d[XLEN-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
            C_OP_ROR: r = {d[0], d[XLEN-1:1]};
`endif
            default:  r = {1'b0, d[XLEN-1:1]};
        endcase
        return r;
    endfunction

    always_comb begin
        k      = (rem_q > C_STEP) ? C_STEP : rem_q;
        data_d = data_q;
        for (int i = 0; i < STEP; i++) begin
            if (SHW'(i) < k) begin
                data_d = f_shift1(data_d, op_q);
            end
        end
        rem_d = rem_q - k;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            dataout_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        data_q     <= datain;
                        op_q       <= op;
                        rem_q      <= shamt;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (shamt == '0) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            dataout_q   <= datain;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q <= data_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        dataout_q   <= data_d;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dataout   = dataout_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
